spi_txn_ctrl: RTL and testbench
===============================

SPI_TXN_CTRL -- requirements
Module: spi_txn_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning max cycles from launch to completion before abort (legal 20..255).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  upstream request present.
REQ-005 req_ready  output  1  controller accepts request this cycle.
REQ-006 req_dev  input  1  target chip-select (0 = CS0, 1 = CS1).
REQ-007 req_data  input  14  word to transmit.
REQ-008 tx_valid  output  1  launch strobe to SPI master.
REQ-009 Data_in  output  14  word presented to SPI master.
REQ-010 CS_Sel  output  1  device select to SPI master.
REQ-011 rx_ready  input  1  SPI master done flag (low while busy, high when idle/done).
REQ-012 Data_out  input  8  received byte from SPI master, valid while rx_ready high after completion.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  downstream consumes response.
REQ-015 rsp_data  output  8  received byte (8'h00 on error).
REQ-016 rsp_err  output  1  transaction timed out.
REQ-017 rsp_dev  output  1  device the response belongs to.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 xfer_cnt  output  8  count of successful transactions.

Function
REQ-020 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE (combinational from state); handshake = req_valid && req_ready at rising edge.
REQ-022 On handshake: latch req_data into Data_in, req_dev into CS_Sel and rsp_dev, clear timeout counter, go LAUNCH next cycle.
REQ-023 In LAUNCH tx_valid SHALL be 1; on sampling rx_ready == 0, tx_valid SHALL drop next cycle and state -> WAIT_DONE.
REQ-024 In WAIT_DONE tx_valid SHALL be 0; on sampling rx_ready == 1, capture Data_out into rsp_data, rsp_err <= 0, xfer_cnt += 1, state -> RESP.
REQ-025 Data_in and CS_Sel SHALL remain stable from handshake until leaving RESP; CS_Sel never changes mid-transaction.
REQ-026 Timeout counter SHALL increment every cycle in LAUNCH or WAIT_DONE; when it equals TIMEOUT-1 without the REQ-023/REQ-024 exit condition, go RESP with rsp_err=1, rsp_data=8'h00, tx_valid=0, xfer_cnt unchanged.
REQ-027 Completion and timeout in the same cycle: completion wins (rsp_err=0).
REQ-028 In RESP rsp_valid SHALL be 1 and rsp_data/rsp_err/rsp_dev stable; on rsp_ready sampled 1 -> IDLE next cycle; no new request accepted in that same cycle.
REQ-029 rsp_valid SHALL be 0 in all other states; minimum request-to-request spacing therefore >= 4 cycles.
REQ-030 xfer_cnt SHALL wrap 255 -> 0 without flag.
REQ-031 req_valid asserted outside IDLE SHALL be ignored (upstream holds it).

Reset
REQ-032 rst low SHALL immediately force: state IDLE, tx_valid 0, Data_in 0, CS_Sel 0, rsp_valid 0, rsp_data 0, rsp_err 0, rsp_dev 0, xfer_cnt 0, timeout counter 0.
REQ-033 Reset mid-transaction SHALL abort without response; first request after release accepted normally.
REQ-034 No output SHALL be X after reset regardless of rx_ready being X.

Verification
REQ-035 Normal: req_dev=1, req_data=14'h2A55, model master drops rx_ready 1 cycle after tx_valid, raises it 18 cycles later with Data_out=8'hC3 -> rsp_valid, rsp_data=8'hC3, rsp_dev=1, rsp_err=0, xfer_cnt=1, CS_Sel=1 throughout.
REQ-036 Timeout: master never drops rx_ready, TIMEOUT=64 -> rsp_valid exactly 64 cycles after LAUNCH entry, rsp_err=1, rsp_data=8'h00, xfer_cnt unchanged.
REQ-037 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid/data stable, req_ready 0, new req_valid ignored until rsp_ready=1.
REQ-038 Race: rx_ready returns high on the cycle counter hits TIMEOUT-1 -> rsp_err=0, data captured.
REQ-039 Reset: rst low during WAIT_DONE -> all outputs reset same cycle, no rsp_valid; next request completes normally.
REQ-040 Wrap: 256 successful transactions -> xfer_cnt returns to 0.

Source files
------------

// File: rtl/spi_txn_if.sv
//==============================================================================
// spi_txn_if : request / SPI-master / response signal bundle for spi_txn_ctrl
// Rev 1.0
//==============================================================================
`default_nettype none

interface spi_txn_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_dev;
    logic [13:0] req_data;
    logic        tx_valid;
    logic [13:0] Data_in;
    logic        CS_Sel;
    logic        rx_ready;
    logic [7:0]  Data_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        rsp_dev;
    logic        busy;
    logic [7:0]  xfer_cnt;

    // slave = the controller; master = the environment around it
    modport slave (
        input  req_valid, req_dev, req_data, rx_ready, Data_out, rsp_ready,
        output req_ready, tx_valid, Data_in, CS_Sel, rsp_valid, rsp_data,
               rsp_err, rsp_dev, busy, xfer_cnt
    );

    modport master (
        output req_valid, req_dev, req_data, rx_ready, Data_out, rsp_ready,
        input  req_ready, tx_valid, Data_in, CS_Sel, rsp_valid, rsp_data,
               rsp_err, rsp_dev, busy, xfer_cnt
    );
endinterface

`default_nettype wire

// File: rtl/spi_txn_ctrl.sv
//==============================================================================
// spi_txn_ctrl : single-outstanding SPI transaction sequencer with timeout
// Rev 1.0
//==============================================================================
`default_nettype none

module spi_txn_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_txn_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tmo_cnt;
    logic [13:0] data_in;
    logic        cs_sel;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        rsp_dev;
    logic [7:0]  xfer_cnt;

    logic handshake;
    logic active;
    logic tmo_hit;
    logic done;
    logic abort;

    assign handshake = bus.req_valid && (state == IDLE);
    assign active    = (state == LAUNCH) || (state == WAIT_DONE);
    // >= rather than == so a late LAUNCH exit cannot slip past the limit
    assign tmo_hit   = (tmo_cnt >= TMO_LAST);
    assign done      = (state == WAIT_DONE) && bus.rx_ready;
    assign abort     = active && !done && (state_nxt == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (handshake)          state_nxt = LAUNCH;
            LAUNCH:    if (!bus.rx_ready)      state_nxt = WAIT_DONE;
                       else if (tmo_hit)       state_nxt = RESP;
            WAIT_DONE: if (bus.rx_ready)       state_nxt = RESP;
                       else if (tmo_hit)       state_nxt = RESP;
            RESP:      if (bus.rsp_ready)      state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt  <= 8'd0;
            data_in  <= 14'd0;
            cs_sel   <= 1'b0;
            rsp_data <= 8'd0;
            rsp_err  <= 1'b0;
            rsp_dev  <= 1'b0;
            xfer_cnt <= 8'd0;
        end else begin
            if (handshake) begin
                data_in <= bus.req_data;
                cs_sel  <= bus.req_dev;
                rsp_dev <= bus.req_dev;
                tmo_cnt <= 8'd0;
            end else if (active) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            // completion has priority over a coincident timeout
            if (done) begin
                rsp_data <= bus.Data_out;
                rsp_err  <= 1'b0;
                xfer_cnt <= xfer_cnt + 8'd1;
            end else if (abort) begin
                rsp_data <= 8'h00;
                rsp_err  <= 1'b1;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.tx_valid  = (state == LAUNCH);
    assign bus.rsp_valid = (state == RESP);
    assign bus.busy      = (state != IDLE);
    assign bus.Data_in   = data_in;
    assign bus.CS_Sel    = cs_sel;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_dev   = rsp_dev;
    assign bus.xfer_cnt  = xfer_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_ctrl.sv
//==============================================================================
// tb_spi_txn_ctrl : directed vector bench for spi_txn_ctrl with model SPI master
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_spi_txn_ctrl;

    localparam int NEVER = 1000;

    typedef struct {
        logic        dev;
        logic [13:0] data;
        int          d;        // cycle index (from LAUNCH entry) where rx_ready drops
        int          b;        // cycles rx_ready stays low
        logic [7:0]  rx;
        int          stall;    // extra RESP cycles with rsp_ready low
        int          lat;      // cycles from LAUNCH entry to RESP entry
        logic        err;
        logic [7:0]  exp_data;
        logic [7:0]  exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [7];

    always #5 clk = ~clk;

    spi_txn_if bus ();

    spi_txn_ctrl #(.TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_data_in"},   32'(bus.Data_in),   32'd0);
        chk({tag, "_cs_sel"},    32'(bus.CS_Sel),    32'd0);
        chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        chk({tag, "_rsp_dev"},   32'(bus.rsp_dev),   32'd0);
        chk({tag, "_xfer_cnt"},  32'(bus.xfer_cnt),  32'd0);
    endtask

    task automatic run_txn(input logic dev, input logic [13:0] data, input int d, input int b,
                           input logic [7:0] rx, input int stall, input int lat, input logic err,
                           input logic [7:0] exp_data, input logic [7:0] exp_cnt);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_dev   = dev;
        bus.req_data  = data;
        bus.rx_ready  = 1'b1;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        // cycle k = k-th cycle after the handshake edge (LAUNCH entry)
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("tx_valid",  32'(bus.tx_valid),  32'((k < lat) && (k <= d)));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(k >= lat));
            chk("cs_sel",    32'(bus.CS_Sel),    32'(dev));
            bus.rx_ready = !((k >= d) && (k < d + b));
            bus.Data_out = (k >= d + b) ? rx : 8'h5A;
        end
        bus.rx_ready = 1'b1;
        chk("rsp_data",  32'(bus.rsp_data),  32'(exp_data));
        chk("rsp_err",   32'(bus.rsp_err),   32'(err));
        chk("rsp_dev",   32'(bus.rsp_dev),   32'(dev));
        chk("xfer_cnt",  32'(bus.xfer_cnt),  32'(exp_cnt));
        chk("data_in",   32'(bus.Data_in),   32'(data));
        chk("req_ready_resp", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = (stall == 0);
        if (stall > 0) begin
            bus.req_valid = 1'b1;
            bus.req_data  = ~data;
            bus.req_dev   = ~dev;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_rsp_data",  32'(bus.rsp_data),  32'(exp_data));
            chk("stall_data_in",   32'(bus.Data_in),   32'(data));
            chk("stall_cs_sel",    32'(bus.CS_Sel),    32'(dev));
            if (i == stall - 1) begin
                bus.rsp_ready = 1'b1;
                bus.req_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_busy",      32'(bus.busy),      32'd0);
        chk("idle_xfer_cnt",  32'(bus.xfer_cnt),  32'(exp_cnt));
        chk("idle_data_in",   32'(bus.Data_in),   32'(data));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          dev   data      d      b    rx     stall lat err  exp_data cnt
        tbl[0] = '{1'b1, 14'h2A55, 1,     18,  8'hC3, 0,    20, 1'b0, 8'hC3, 8'd1};
        tbl[1] = '{1'b0, 14'h1234, NEVER, 0,   8'h77, 0,    64, 1'b1, 8'h00, 8'd1};
        tbl[2] = '{1'b1, 14'h3FFF, 2,     5,   8'h7E, 10,   8,  1'b0, 8'h7E, 8'd2};
        tbl[3] = '{1'b0, 14'h0001, 1,     62,  8'hA5, 0,    64, 1'b0, 8'hA5, 8'd3};
        tbl[4] = '{1'b1, 14'h2000, 1,     63,  8'h99, 0,    64, 1'b1, 8'h00, 8'd3};
        tbl[5] = '{1'b0, 14'h0ABC, 0,     1,   8'h11, 0,    2,  1'b0, 8'h11, 8'd4};
        tbl[6] = '{1'b1, 14'h1555, 1,     200, 8'h22, 3,    64, 1'b1, 8'h00, 8'd4};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_dev   = 1'b0;
        bus.req_data  = 14'd0;
        bus.rsp_ready = 1'b0;
        bus.rx_ready  = 1'bx;
        bus.Data_out  = 8'hxx;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        bus.rx_ready = 1'b1;
        bus.Data_out = 8'h00;
        rst_n        = 1'b1;

        foreach (tbl[i]) begin
            run_txn(tbl[i].dev, tbl[i].data, tbl[i].d, tbl[i].b, tbl[i].rx, tbl[i].stall,
                    tbl[i].lat, tbl[i].err, tbl[i].exp_data, tbl[i].exp_cnt);
        end

        // asynchronous reset while waiting on the SPI master
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_dev   = 1'b1;
        bus.req_data  = 14'h1357;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rx_ready  = 1'b0;
        repeat (5) @(negedge clk);
        chk("wait_busy",     32'(bus.busy),     32'd1);
        chk("wait_tx_valid", 32'(bus.tx_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        run_txn(1'b0, 14'h0F5A, 1, 3, 8'h6C, 0, 5, 1'b0, 8'h6C, 8'd1);

        // counter wrap over 256 back-to-back successes
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            run_txn(i[0], 14'(i * 37), 0, 1, i[7:0], 0, 2, 1'b0, i[7:0], 8'(i + 1));
        end
        chk("wrap_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
